// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch front end and the
// decode-side immediate generator.
package ifu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ifu_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RV32 base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory, branch unit and decode.
// master = fetch controller side, slave = environment side.
interface instr_fetch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two >= 2.
// Storage is not reset; only pointers and occupancy are.
module ifu_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    input  logic                    flush,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        // Flush discards everything, including a same-cycle push or pop
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC, credit-limited IMEM requests, instruction buffer,
// redirect flush/drain. Optional stall counter when IFU_PERF_EN is defined.
module instr_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_ctrl_if.master  bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt
`endif
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;

    logic              credit_ok, req_valid, req_fire, rsp_ok, rsp_push, dec_pop, buf_valid;
    logic [XLEN-1:0]   redirect_tgt, tag_pc, head_pc, head_instr;
    logic [2*XLEN-1:0] buf_rdata;
    logic [CW-1:0]     fifo_count, tag_count;

    always_comb begin
        redirect_tgt  = bus.redirect_pc & ~XLEN'(3);
        // Credits cover both in-flight requests and buffered instructions, so a
        // response always has a slot waiting for it.
        credit_ok     = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_L;
        req_valid     = (state_q == RUN) && !bus.redirect_valid && credit_ok;
        req_fire      = req_valid && bus.imem_req_ready;
        rsp_ok        = bus.imem_rsp_valid && (outstanding_q != '0);
        rsp_push      = rsp_ok && (state_q == RUN) && !bus.redirect_valid;
        buf_valid     = (fifo_count != '0);
        dec_pop       = buf_valid && bus.dec_ready;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);

        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = redirect_tgt;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (bus.redirect_valid && (outstanding_d != '0)) state_d = DRAIN;
            DRAIN:   if (outstanding_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Tags of issued addresses, consumed in order by every response (kept or dropped)
    ifu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(req_fire), .wdata(pc_q), .pop(rsp_ok), .flush(1'b0),
        .rdata(tag_pc), .count(tag_count)
    );

    ifu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_instr_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(rsp_push), .wdata({tag_pc, bus.imem_rsp_data}), .pop(dec_pop),
        .flush(bus.redirect_valid),
        .rdata(buf_rdata), .count(fifo_count)
    );

    assign {head_pc, head_instr} = buf_rdata;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = buf_valid;
    assign bus.dec_instr      = buf_valid ? head_instr : XLEN'(NOP_INSTR);
    assign bus.dec_pc         = buf_valid ? head_pc : '0;

`ifdef IFU_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN) && !buf_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outstanding_q != '0));
    a_tags_track_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == outstanding_q);
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand-written redirect/stall
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if #(.XLEN(32)) bus();
`ifdef IFU_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef IFU_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired at t=%0t", name, $time);
    endtask

    // Instruction memory content: any fixed function of the address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0093;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] addr; bit discard; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } de_t;

    fl_t         inflight[$];
    de_t         expq[$];
    logic [31:0] mpc;
    bit          started;
    int          perf_exp;
    logic [31:0] fire_log[$];
    logic [31:0] dec_log[$];

    function automatic void model_reset();
        inflight.delete();
        expq.delete();
        mpc      = 32'h0;
        started  = 1'b0;
        perf_exp = 0;
    endfunction

    function automatic bit draining();
        return (inflight.size() > 0) && inflight[0].discard;
    endfunction

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  bus.imem_req_addr, 32'h0);
        check({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
        check({tag, "_dec_instr"}, bus.dec_instr, NOP);
        check({tag, "_dec_pc"},    bus.dec_pc, 32'h0);
`ifdef IFU_PERF_EN
        check({tag, "_perf"},      perf_stall_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, compare, advance the model across the rising edge
    task automatic cycle(input bit rdy, input bit rsp_en, input bit drdy, input bit redir,
                         input logic [31:0] rpc);
        bit  rsp, exp_req, exp_dv, req_fire;
        fl_t f;
        rsp = rsp_en && (inflight.size() > 0);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? instr_of(inflight[0].addr) : $urandom;
        bus.dec_ready      = drdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        exp_req = started && !redir && !draining() && ((inflight.size() + expq.size()) < DEPTH);
        exp_dv  = (expq.size() != 0);
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        check("req_addr",  bus.imem_req_addr, mpc);
        check("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
        check("dec_pc",    bus.dec_pc,    exp_dv ? expq[0].pc    : 32'h0);
        check("dec_instr", bus.dec_instr, exp_dv ? expq[0].instr : NOP);
`ifdef IFU_PERF_EN
        check("perf_cnt", perf_stall_cnt, 32'(perf_exp));
        if (started && !draining() && !exp_dv) perf_exp++;
`endif
        if (bus.imem_req_valid && rdy) fire_log.push_back(bus.imem_req_addr);
        if (bus.dec_valid && drdy)     dec_log.push_back(bus.dec_pc);

        req_fire = exp_req && rdy;
        if (exp_dv && drdy) void'(expq.pop_front());
        if (rsp) begin
            f = inflight.pop_front();
            if (!f.discard && !redir) expq.push_back('{pc: f.addr, instr: instr_of(f.addr)});
        end
        if (redir) begin
            expq.delete();
            foreach (inflight[i]) inflight[i].discard = 1'b1;
            mpc = rpc & ~32'h3;
        end
        if (req_fire) begin
            inflight.push_back('{addr: mpc, discard: 1'b0});
            mpc = mpc + 32'd4;
        end
        started = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rdy; bit rsp; logic [31:0] rdata; bit drdy;
        bit e_rv; logic [31:0] e_addr; bit e_dv; logic [31:0] e_pc; logic [31:0] e_instr;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] early_instr;
    bit          reached;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b0, 32'h0, NOP};
        tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  1'b0, 32'h0, NOP};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0093, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, NOP};
        tbl[3] = '{1'b1, 1'b1, 32'h0010_0113, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0, 32'h0000_0093};
        tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'h0010_0113};
        tbl[5] = '{1'b1, 1'b1, 32'h0020_0193, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0, NOP};
        tbl[6] = '{1'b1, 1'b1, 32'h0030_0213, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8, 32'h0020_0193};
        tbl[7] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'h0030_0213};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch from reset: latency and back-to-back flow
        for (int i = 0; i < 8; i++) begin
            bus.imem_req_ready = tbl[i].rdy;
            bus.imem_rsp_valid = tbl[i].rsp;
            bus.imem_rsp_data  = tbl[i].rdata;
            bus.dec_ready      = tbl[i].drdy;
            bus.redirect_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
            check($sformatf("tbl%0d_req_addr", i),  bus.imem_req_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_dec_valid", i), 32'(bus.dec_valid), 32'(tbl[i].e_dv));
            check($sformatf("tbl%0d_dec_pc", i),    bus.dec_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_dec_instr", i), bus.dec_instr, tbl[i].e_instr);
            @(negedge clk);
        end

        // Decode backpressure: requests stop once credits are used, head stays put
        do_reset();
        repeat (4) cycle(1, 1, 1, 0, 32'h0);
        fire_log.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0, 32'h0);
            if (i == 1) early_instr = bus.dec_instr;
        end
        check("stall_req_count_le2", 32'(fire_log.size() <= 2), 32'd1);
        check("stall_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        check("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
        check("stall_instr_stable", bus.dec_instr, early_instr);
        dec_log.delete();
        repeat (3) cycle(1, 1, 1, 0, 32'h0);
        check("stall_resumed", 32'(dec_log.size() > 0), 32'd1);

        // Redirect to 0x103 with two requests in flight
        reached = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (inflight.size() == 2) begin reached = 1'b1; break; end
            cycle(1, 0, 1, 0, 32'h0);
        end
        if (!reached) bound_expired("redir_setup");
        fire_log.delete();
        dec_log.delete();
        cycle(0, 0, 1, 1, 32'h103);
        cycle(1, 0, 1, 0, 32'h0);
        check("redir_no_req_in_drain", 32'(fire_log.size()), 32'd0);
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dec_log.size() > 0) begin reached = 1'b1; break; end
            cycle(1, 1, 1, 0, 32'h0);
        end
        if (!reached) bound_expired("redir_first_dec");
        check("redir_first_req", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'h100);
        check("redir_first_dec_pc", (dec_log.size() > 0) ? dec_log[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect together with a decode pop and a response
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inflight.size() == 0 && expq.size() == 0) begin reached = 1'b1; break; end
            cycle(0, 1, 1, 0, 32'h0);
        end
        if (!reached) bound_expired("pop_redir_drain");
        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 32'h0);
        if (!(expq.size() == 1 && inflight.size() == 1)) bound_expired("pop_redir_setup");
        dec_log.delete();
        cycle(0, 1, 1, 1, 32'h200);
        check("pop_redir_consumed", 32'(dec_log.size()), 32'd1);
        check("pop_redir_fifo_empty", 32'(bus.dec_valid), 32'd0);

        // PC wrap at the top of the address space
        fire_log.delete();
        cycle(0, 1, 1, 1, 32'hFFFF_FFFC);
        reached = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (fire_log.size() >= 2) begin reached = 1'b1; break; end
            cycle(1, 1, 1, 0, 32'h0);
        end
        if (!reached) bound_expired("wrap_reqs");
        check("wrap_req0", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_req1", (fire_log.size() > 1) ? fire_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
        end

`ifdef IFU_PERF_EN
        do_reset();
        repeat (8) cycle(0, 0, 1, 0, 32'h0);
        check("perf_seven_stalls", perf_stall_cnt, 32'd7);
        repeat (3) cycle(1, 1, 1, 0, 32'h0);
`endif

        // Asynchronous reset in the middle of a clock period
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
